// File: rtl/ahfp_norm48.sv
// Two-stage 48-bit mantissa normalizer: leading-zero count in S1, shift and
// exponent adjust into the S2 output register, valid/ready on both sides.
module ahfp_norm48 #(
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_in_sign,
  input  logic [47:0]      i_in_mant,
  input  logic [EXP_W-1:0] i_in_exp,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_sign,
  output logic [47:0]      o_out_mant,
  output logic [EXP_W-1:0] o_out_exp,
  output logic             o_out_zero,
  output logic             o_out_denorm
);

  logic             r_s1_v;
  logic             r_s1_sign;
  logic [47:0]      r_s1_mant;
  logic [EXP_W-1:0] r_s1_exp;

  logic             r_s2_v;
  logic             r_s2_sign;
  logic [47:0]      r_s2_mant;
  logic [EXP_W-1:0] r_s2_exp;
  logic             r_s2_zero;
  logic             r_s2_denorm;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [5:0]       w_lz;
  logic [EXP_W-1:0] w_lz_e;
  logic [EXP_W-1:0] w_expm1;
  logic             w_z;
  logic [47:0]      w_mant;
  logic [EXP_W-1:0] w_exp;
  logic             w_zero;
  logic             w_denorm;

  assign w_s2_adv   = !r_s2_v || i_out_ready;
  assign w_s1_adv   = !r_s1_v || w_s2_adv;
  assign o_in_ready = w_s1_adv;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    w_lz = 6'd47;
    for (int i = 0; i < 48; i++) begin
      if (r_s1_mant[i]) w_lz = 6'(47 - i);
    end
  end

  assign w_z     = (r_s1_mant == 48'd0);
  assign w_lz_e  = EXP_W'(w_lz);
  assign w_expm1 = r_s1_exp - EXP_W'(1);

  // In the clamp branch exp <= lz <= 47, so the low 6 bits of exp-1 are exact.
  always_comb begin
    w_mant   = '0;
    w_exp    = '0;
    w_zero   = 1'b0;
    w_denorm = 1'b0;
    if (w_z) begin
      w_zero = 1'b1;
    end else if (w_lz_e < r_s1_exp) begin
      w_mant = r_s1_mant << w_lz;
      w_exp  = r_s1_exp - w_lz_e;
    end else begin
      w_denorm = 1'b1;
      w_mant   = (r_s1_exp == '0) ? r_s1_mant : (r_s1_mant << w_expm1[5:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_mant <= '0;
      r_s1_exp  <= '0;
    end else if (w_s1_adv) begin
      r_s1_v <= i_in_valid;
      if (i_in_valid) begin
        r_s1_sign <= i_in_sign;
        r_s1_mant <= i_in_mant;
        r_s1_exp  <= i_in_exp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v      <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_mant   <= '0;
      r_s2_exp    <= '0;
      r_s2_zero   <= 1'b0;
      r_s2_denorm <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_sign   <= r_s1_sign;
        r_s2_mant   <= w_mant;
        r_s2_exp    <= w_exp;
        r_s2_zero   <= w_zero;
        r_s2_denorm <= w_denorm;
      end
    end
  end

  assign o_out_valid  = r_s2_v;
  assign o_out_sign   = r_s2_sign;
  assign o_out_mant   = r_s2_mant;
  assign o_out_exp    = r_s2_exp;
  assign o_out_zero   = r_s2_zero;
  assign o_out_denorm = r_s2_denorm;

endmodule
